// File: rtl/multi_bit_sync_filter.sv
// rtl/multi_bit_sync_filter.sv - per-bit CDC synchronizer with glitch filter and edge pulses
// Each channel is synchronized independently, then accepted only after holding a new level.
module multi_bit_sync_filter #(
    parameter int                   NUM_STAGES    = 2,
    parameter int                   BIT_WIDTH     = 4,
    parameter int                   FILTER_CYCLES = 4,
    parameter logic [BIT_WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic                 clkB,
    input  logic                 rstB,
    input  logic [BIT_WIDTH-1:0] dinA,
    output logic [BIT_WIDTH-1:0] doutB,
    output logic [BIT_WIDTH-1:0] riseB,
    output logic [BIT_WIDTH-1:0] fallB,
    output logic                 changeB
);

    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    generate
        if (NUM_STAGES < 2 || FILTER_CYCLES < 1 || BIT_WIDTH < 1) begin : gParamCheck
            $error("multi_bit_sync_filter: illegal parameter combination");
        end
    endgenerate

    logic [BIT_WIDTH-1:0] syncChain [NUM_STAGES];
    logic [CNT_W-1:0]     cnt       [BIT_WIDTH];
    logic [BIT_WIDTH-1:0] syncd;

    assign syncd = syncChain[NUM_STAGES-1];

    // Plain flop chain: nothing between stages so the tools see a clean synchronizer.
    always_ff @(posedge clkB) begin
        if (rstB) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                syncChain[s] <= RESET_VALUE;
            end
        end else begin
            syncChain[0] <= dinA;
            for (int s = 1; s < NUM_STAGES; s++) begin
                syncChain[s] <= syncChain[s-1];
            end
        end
    end

    always_ff @(posedge clkB) begin
        if (rstB) begin
            doutB <= RESET_VALUE;
            riseB <= '0;
            fallB <= '0;
            for (int i = 0; i < BIT_WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BIT_WIDTH; i++) begin
                riseB[i] <= 1'b0;
                fallB[i] <= 1'b0;
                // Any return to the accepted level throws away the partial count.
                if (syncd[i] == doutB[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    doutB[i] <= syncd[i];
                    cnt[i]   <= '0;
                    riseB[i] <= syncd[i];
                    fallB[i] <= ~syncd[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign changeB = |(riseB | fallB);

endmodule

// File: tb/tb_multi_bit_sync_filter.sv
// tb/tb_multi_bit_sync_filter.sv - scoreboard bench for default and fast/wide filter configurations
module tb_multi_bit_sync_filter;

    logic clkB = 1'b0;
    always #5 clkB = ~clkB;

    logic       rstA, chgA;
    logic [3:0] dinA4, doutA4, riseA4, fallA4;
    logic       rstW, chgW;
    logic [7:0] dinW8, doutW8, riseW8, fallW8;

    multi_bit_sync_filter dutA (
        .clkB(clkB), .rstB(rstA), .dinA(dinA4),
        .doutB(doutA4), .riseB(riseA4), .fallB(fallA4), .changeB(chgA)
    );

    multi_bit_sync_filter #(.NUM_STAGES(3), .BIT_WIDTH(8), .FILTER_CYCLES(1), .RESET_VALUE(8'h00)) dutW (
        .clkB(clkB), .rstB(rstW), .dinA(dinW8),
        .doutB(doutW8), .riseB(riseW8), .fallB(fallW8), .changeB(chgW)
    );

    typedef struct packed {
        logic [7:0] dout;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       chg;
    } expT;

    expT qA[$];
    expT qW[$];
    int  compared   = 0;
    int  mismatched = 0;

    // Default instance: NUM_STAGES=2, FILTER_CYCLES=4, change visible 5 edges after sampling.
    task automatic stepA(input logic [3:0] din, input logic rst, input logic [3:0] dout,
                         input logic [3:0] rise, input logic [3:0] fall);
        expT e;
        e.dout = {4'b0, dout};
        e.rise = {4'b0, rise};
        e.fall = {4'b0, fall};
        e.chg  = |(rise | fall);
        rstA   = rst;
        dinA4  = din;
        qA.push_back(e);
        @(posedge clkB);
        #2;
    endtask

    task automatic holdA(input logic [3:0] din, input int n, input logic [3:0] dout);
        repeat (n) stepA(din, 1'b0, dout, 4'b0, 4'b0);
    endtask

    task automatic changeA(input logic [3:0] din, input logic [3:0] oldD, input logic [3:0] newD,
                           input logic [3:0] rise, input logic [3:0] fall);
        repeat (5) stepA(din, 1'b0, oldD, 4'b0, 4'b0);
        stepA(din, 1'b0, newD, rise, fall);
    endtask

    // Wide instance: NUM_STAGES=3, FILTER_CYCLES=1, change visible 3 edges after sampling.
    task automatic stepW(input logic [7:0] din, input logic rst, input logic [7:0] dout,
                         input logic [7:0] rise, input logic [7:0] fall);
        expT e;
        e.dout = dout;
        e.rise = rise;
        e.fall = fall;
        e.chg  = |(rise | fall);
        rstW   = rst;
        dinW8  = din;
        qW.push_back(e);
        @(posedge clkB);
        #2;
    endtask

    task automatic holdW(input logic [7:0] din, input int n, input logic [7:0] dout);
        repeat (n) stepW(din, 1'b0, dout, 8'h00, 8'h00);
    endtask

    task automatic seqA();
        repeat (3) stepA(4'b1111, 1'b1, 4'b0000, 4'b0, 4'b0);
        holdA(4'b0000, 2, 4'b0000);
        changeA(4'b1010, 4'b0000, 4'b1010, 4'b1010, 4'b0000);
        holdA(4'b1010, 3, 4'b1010);
        repeat (3) stepA(4'b1011, 1'b0, 4'b1010, 4'b0, 4'b0);
        holdA(4'b1010, 6, 4'b1010);
        changeA(4'b1011, 4'b1010, 4'b1011, 4'b0001, 4'b0000);
        holdA(4'b1011, 2, 4'b1011);
        changeA(4'b1010, 4'b1011, 4'b1010, 4'b0000, 4'b0001);
        holdA(4'b1010, 2, 4'b1010);
        changeA(4'b0101, 4'b1010, 4'b0101, 4'b0101, 4'b1010);
        holdA(4'b0101, 2, 4'b0101);
        holdA(4'b1101, 2, 4'b0101);
        holdA(4'b0101, 1, 4'b0101);
        holdA(4'b1101, 2, 4'b0101);
        holdA(4'b0101, 6, 4'b0101);
        changeA(4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0101);
        holdA(4'b0000, 2, 4'b0000);
        holdA(4'b1111, 3, 4'b0000);
        stepA(4'b1111, 1'b1, 4'b0000, 4'b0, 4'b0);
        changeA(4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000);
        holdA(4'b1111, 2, 4'b1111);
        stepA(4'b1111, 1'b1, 4'b0000, 4'b0, 4'b0);
        changeA(4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000);
        holdA(4'b1111, 2, 4'b1111);
    endtask

    task automatic seqW();
        repeat (2) stepW(8'hFF, 1'b1, 8'h00, 8'h00, 8'h00);
        holdW(8'h00, 3, 8'h00);
        holdW(8'hA5, 3, 8'h00);
        stepW(8'hA5, 1'b0, 8'hA5, 8'hA5, 8'h00);
        holdW(8'hA5, 2, 8'hA5);
        stepW(8'hA4, 1'b0, 8'hA5, 8'h00, 8'h00);
        holdW(8'hA5, 2, 8'hA5);
        stepW(8'hA5, 1'b0, 8'hA4, 8'h00, 8'h01);
        stepW(8'hA5, 1'b0, 8'hA5, 8'h01, 8'h00);
        holdW(8'hA5, 2, 8'hA5);
        holdW(8'h5A, 3, 8'hA5);
        stepW(8'h5A, 1'b0, 8'h5A, 8'h5A, 8'hA5);
        holdW(8'h5A, 2, 8'h5A);
    endtask

    initial begin : monitor
        expT e;
        int  nA = 0;
        int  nW = 0;
        forever begin
            @(posedge clkB);
            #1;
            if (qA.size() > 0) begin
                e = qA.pop_front();
                compared++;
                if ({doutA4, riseA4, fallA4, chgA} !== {e.dout[3:0], e.rise[3:0], e.fall[3:0], e.chg}) begin
                    mismatched++;
                    $display("FAIL dutA step %0d: got dout=%b rise=%b fall=%b chg=%b, expected dout=%b rise=%b fall=%b chg=%b",
                             nA, doutA4, riseA4, fallA4, chgA, e.dout[3:0], e.rise[3:0], e.fall[3:0], e.chg);
                end
                nA++;
            end
            if (qW.size() > 0) begin
                e = qW.pop_front();
                compared++;
                if ({doutW8, riseW8, fallW8, chgW} !== {e.dout, e.rise, e.fall, e.chg}) begin
                    mismatched++;
                    $display("FAIL dutW step %0d: got dout=%h rise=%h fall=%h chg=%b, expected dout=%h rise=%h fall=%h chg=%b",
                             nW, doutW8, riseW8, fallW8, chgW, e.dout, e.rise, e.fall, e.chg);
                end
                nW++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        fork
            seqA();
            seqW();
        join
        repeat (3) @(posedge clkB);
        #3;
        compared++;
        if (qA.size() != 0) begin
            mismatched++;
            $display("FAIL dutA drain: %0d entries left, expected 0", qA.size());
        end
        compared++;
        if (qW.size() != 0) begin
            mismatched++;
            $display("FAIL dutW drain: %0d entries left, expected 0", qW.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multi_bit_sync_filter.md
MULTI_BIT_SYNC_FILTER -- requirements
Module: multi_bit_sync_filter

Interface
REQ-001 The block SHALL have parameter NUM_STAGES, default 2, meaning the synchronizer flop depth per bit; minimum 2.
REQ-002 The block SHALL have parameter BIT_WIDTH, default 4, meaning the number of independent channels (bits).
REQ-003 The block SHALL have parameter FILTER_CYCLES, default 4, meaning the consecutive post-sync cycles a new level must hold before acceptance; minimum 1 (1 = no filtering).
REQ-004 The block SHALL have parameter RESET_VALUE [BIT_WIDTH-1:0], default 0, meaning the reset level of the sync chain and doutB.
REQ-005 The block SHALL have port clkB  input  1  destination-domain clock.
REQ-006 The block SHALL have port rstB  input  1  reset, synchronous, active-high.
REQ-007 The block SHALL have port dinA  input  BIT_WIDTH  asynchronous source-domain levels.
REQ-008 The block SHALL have port doutB  output  BIT_WIDTH  synchronized, filtered levels (registered).
REQ-009 The block SHALL have port riseB  output  BIT_WIDTH  one-cycle pulse per bit on an accepted 0->1 doutB change (registered).
REQ-010 The block SHALL have port fallB  output  BIT_WIDTH  one-cycle pulse per bit on an accepted 1->0 doutB change (registered).
REQ-011 The block SHALL have port changeB  output  1  OR-reduction of riseB|fallB.

Function
REQ-012 Each bit SHALL pass through a NUM_STAGES-deep flop chain clocked by clkB, with no logic between stages; syncd = last stage.
REQ-013 Each bit SHALL have its own counter, width clog2(FILTER_CYCLES+1), and bits SHALL operate fully independently.
REQ-014 When syncd[i]==doutB[i], cnt[i] SHALL clear to 0 at the next edge.
REQ-015 When syncd[i]!=doutB[i] and cnt[i]<FILTER_CYCLES-1, cnt[i] SHALL increment by 1.
REQ-016 When syncd[i]!=doutB[i] and cnt[i]==FILTER_CYCLES-1, doutB[i]<=syncd[i], cnt[i]<=0, and riseB[i] or fallB[i] SHALL assert for that cycle only.
REQ-017 riseB/fallB SHALL be 0 in every cycle without an accepted update; rise and fall on different bits in the same cycle SHALL be reported together.
REQ-018 Latency: dinA stable from sampling edge k SHALL appear on doutB after edge k+NUM_STAGES+FILTER_CYCLES-1 (default: 5 edges); pulses SHALL appear in the same cycle as the doutB update.
REQ-019 A syncd deviation lasting fewer than FILTER_CYCLES consecutive cycles SHALL be rejected: no doutB change, no pulse, counter cleared.
REQ-020 A return of syncd to doutB mid-count SHALL restart the count from 0 on the next deviation (no accumulation).
REQ-021 Elaboration SHALL fail for NUM_STAGES<2, FILTER_CYCLES<1 or BIT_WIDTH<1.

Reset
REQ-022 At any clkB edge with rstB=1, all sync flops and doutB SHALL load RESET_VALUE, all counters 0, riseB=fallB=0.
REQ-023 Reset asserted mid-count SHALL discard the pending change; no pulse SHALL be generated on entering or leaving reset.
REQ-024 After rstB deasserts with dinA!=RESET_VALUE, differing bits SHALL update after the REQ-018 latency with normal pulses.

Verification (defaults unless stated)
REQ-025 rstB=1 for 3 edges, dinA=4'b1111 -> doutB=4'b0000, riseB=fallB=0, changeB=0 throughout reset.
REQ-026 After reset, dinA 0000->1010 held -> doutB=1010 exactly 5 edges after sampling edge; riseB=1010, fallB=0000, changeB=1 for one cycle only.
REQ-027 Bit0 high for 3 cycles then low -> doutB and pulses unchanged; high for 4+ cycles -> doutB[0]=1 with riseB[0] pulse.
REQ-028 doutB=1010, dinA->0101 -> doutB=0101 with riseB=0101 and fallB=1010 in the same cycle.
REQ-029 dinA 0000->1111, rstB=1 for one edge 3 edges later -> doutB stays 0000, no pulses; after release, doutB=1111 5 edges after the first post-reset sampling edge.
REQ-030 NUM_STAGES=3, FILTER_CYCLES=1, BIT_WIDTH=8 -> any change appears on doutB after 3 edges; one-cycle input pulses propagate unfiltered.
